// File: rtl/pmux_src.sv
// Select-sequence source for a parallel mux stage: an 8-entry data bank plus
// an FSM that streams frames of four strided select values under valid/ready.
module pmux_src #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [2:0]       wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             start_i,
   input  logic [2:0]       base_i,
   input  logic [2:0]       stride_i,
   input  logic [7:0]       count_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [2:0]       sel_0_o,
   output logic [2:0]       sel_1_o,
   output logic [2:0]       sel_2_o,
   output logic [2:0]       sel_3_o,
   output logic [WIDTH-1:0] data_0_o,
   output logic [WIDTH-1:0] data_1_o,
   output logic [WIDTH-1:0] data_2_o,
   output logic [WIDTH-1:0] data_3_o,
   output logic [WIDTH-1:0] data_4_o,
   output logic [WIDTH-1:0] data_5_o,
   output logic [WIDTH-1:0] data_6_o,
   output logic [WIDTH-1:0] data_7_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             wr_err_o,
   output logic [1:0]       state_o
);

   // Handshake: a frame transfers on a rising edge where valid_o and ready_i
   // are both high; once raised, valid_o and sel_*_o hold until that edge.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] bank [8];
   logic [2:0]       sel_q [4];
   logic [2:0]       cur_base;
   logic [2:0]       stride_q;
   logic [7:0]       cnt;

   // Select k of a frame: base + k*stride, wrapping in 3 bits.
   function automatic logic [2:0] sel_at(input logic [2:0] b, input logic [2:0] s,
                                         input logic [1:0] k);
      logic [2:0] s2;
      logic [2:0] s3;
      s2 = {s[1:0], 1'b0};
      s3 = s2 + s;
      case (k)
         2'd0:    sel_at = b;
         2'd1:    sel_at = b + s;
         2'd2:    sel_at = b + s2;
         default: sel_at = b + s3;
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         valid_o  <= 1'b0;
         done_o   <= 1'b0;
         wr_err_o <= 1'b0;
         cur_base <= 3'd0;
         stride_q <= 3'd0;
         cnt      <= 8'd0;
         for (int i = 0; i < 8; i++) bank[i] <= '0;
         for (int k = 0; k < 4; k++) sel_q[k] <= 3'd0;
      end else begin
         done_o   <= 1'b0;
         wr_err_o <= 1'b0;

         if (wr_en_i) begin
            if (state == RUN) wr_err_o <= 1'b1;
            else              bank[wr_addr_i] <= wr_data_i;
         end

         case (state)
            IDLE: begin
               if (start_i && (count_i != 8'd0)) begin
                  state    <= RUN;
                  cur_base <= base_i;
                  stride_q <= stride_i;
                  cnt      <= count_i;
                  valid_o  <= 1'b1;
                  for (int k = 0; k < 4; k++) sel_q[k] <= sel_at(base_i, stride_i, 2'(k));
               end
            end
            RUN: begin
               if (valid_o && ready_i) begin
                  cnt      <= cnt - 8'd1;
                  cur_base <= cur_base + 3'd1;
                  if (cnt == 8'd1) begin
                     state   <= DONE;
                     valid_o <= 1'b0;
                     done_o  <= 1'b1;
                  end else begin
                     for (int k = 0; k < 4; k++)
                        sel_q[k] <= sel_at(cur_base + 3'd1, stride_q, 2'(k));
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o  = (state != IDLE);
   assign state_o = state;

   assign sel_0_o = sel_q[0];
   assign sel_1_o = sel_q[1];
   assign sel_2_o = sel_q[2];
   assign sel_3_o = sel_q[3];

   assign data_0_o = bank[0];
   assign data_1_o = bank[1];
   assign data_2_o = bank[2];
   assign data_3_o = bank[3];
   assign data_4_o = bank[4];
   assign data_5_o = bank[5];
   assign data_6_o = bank[6];
   assign data_7_o = bank[7];

endmodule

// File: tb/tb_pmux_src.sv
// Directed bench for pmux_src: the driver pushes hand-computed frames into a
// queue and a negedge monitor pops and compares one per handshake.
module tb_pmux_src;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_en;
   logic [2:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic         start;
   logic [2:0]   base;
   logic [2:0]   stride;
   logic [7:0]   count;
   logic         ready;
   logic         valid_o;
   logic [2:0]   sel_0, sel_1, sel_2, sel_3;
   logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
   logic         busy_o, done_o, wr_err_o;
   logic [1:0]   state_o;
   logic [11:0]  frame;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   logic [11:0] exp_q[$];

   pmux_src #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .start_i(start), .base_i(base), .stride_i(stride),
      .count_i(count), .ready_i(ready), .valid_o(valid_o),
      .sel_0_o(sel_0), .sel_1_o(sel_1), .sel_2_o(sel_2), .sel_3_o(sel_3),
      .data_0_o(d0), .data_1_o(d1), .data_2_o(d2), .data_3_o(d3),
      .data_4_o(d4), .data_5_o(d5), .data_6_o(d6), .data_7_o(d7),
      .busy_o(busy_o), .done_o(done_o), .wr_err_o(wr_err_o), .state_o(state_o)
   );

   assign frame = {sel_0, sel_1, sel_2, sel_3};

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] fr(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] c, input logic [2:0] d);
      return {a, b, c, d};
   endfunction

   task automatic do_start(input logic [2:0] b, input logic [2:0] s, input logic [7:0] c);
      start = 1'b1; base = b; stride = s; count = c;
      step();
      start = 1'b0;
   endtask

   // monitor / scoreboard
   initial begin
      logic        prev_wait;
      logic [11:0] prev_frame;
      logic [11:0] e;
      prev_wait  = 1'b0;
      prev_frame = '0;
      forever begin
         @(negedge clk);
         if (rst_n && prev_wait) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_sel", 32'(frame), 32'(prev_frame));
         end
         if (done_o) done_seen++;
         if (rst_n && valid_o && ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame actual=%0h expected=none", frame);
            end else begin
               e = exp_q.pop_front();
               chk("frame", 32'(frame), 32'(e));
            end
            prev_wait = 1'b0;
         end else begin
            prev_wait = rst_n && valid_o;
         end
         prev_frame = frame;
      end
   end

   // driver
   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; base = '0; stride = '0; count = '0; ready = 1'b0;
      #3;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_wr_err", 32'(wr_err_o), 32'd0);
      chk("rst_sel", 32'(frame), 32'd0);
      chk("rst_data0", 32'(d0), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // bank write / readback
      wr_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wr_addr = 3'(k);
         wr_data = 16'h1000 + 16'(k);
         step();
         case (k)
            0: chk("bank0", 32'(d0), 32'h1000);
            1: chk("bank1", 32'(d1), 32'h1001);
            2: chk("bank2", 32'(d2), 32'h1002);
            3: chk("bank3", 32'(d3), 32'h1003);
            4: chk("bank4", 32'(d4), 32'h1004);
            5: chk("bank5", 32'(d5), 32'h1005);
            6: chk("bank6", 32'(d6), 32'h1006);
            default: chk("bank7", 32'(d7), 32'h1007);
         endcase
      end
      wr_en = 1'b0;
      step();

      // full-throughput sequence
      ready = 1'b1;
      exp_q.push_back(fr(6, 1, 4, 7));
      exp_q.push_back(fr(7, 2, 5, 0));
      do_start(3'd6, 3'd3, 8'd2);
      chk("seq_valid_t1", 32'(valid_o), 32'd1);
      chk("seq_busy", 32'(busy_o), 32'd1);
      step();
      chk("seq_valid_f2", 32'(valid_o), 32'd1);
      step();
      chk("seq_done", 32'(done_o), 32'd1);
      chk("seq_valid_off", 32'(valid_o), 32'd0);
      chk("seq_busy_done", 32'(busy_o), 32'd1);
      chk("seq_sel_hold", 32'(frame), 32'(fr(7, 2, 5, 0)));
      step();
      chk("seq_done_pulse", 32'(done_o), 32'd0);
      chk("seq_idle_busy", 32'(busy_o), 32'd0);

      // backpressure
      ready = 1'b0;
      exp_q.push_back(fr(0, 1, 2, 3));
      do_start(3'd0, 3'd1, 8'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(valid_o), 32'd1);
         chk("bp_sel", 32'(frame), 32'(fr(0, 1, 2, 3)));
         if (i < 4) step();
      end
      ready = 1'b1;
      step();
      chk("bp_done", 32'(done_o), 32'd1);
      chk("bp_valid_off", 32'(valid_o), 32'd0);
      step();

      // rejected write and start during RUN
      ready = 1'b0;
      exp_q.push_back(fr(2, 7, 4, 1));
      do_start(3'd2, 3'd5, 8'd1);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
      start = 1'b1; base = 3'd0; stride = 3'd0; count = 8'd9;
      step();
      wr_en = 1'b0; start = 1'b0;
      chk("rej_wr_err", 32'(wr_err_o), 32'd1);
      chk("rej_bank", 32'(d3), 32'h1003);
      chk("rej_sel", 32'(frame), 32'(fr(2, 7, 4, 1)));
      step();
      chk("rej_wr_err_pulse", 32'(wr_err_o), 32'd0);
      ready = 1'b1;
      step();
      chk("rej_done", 32'(done_o), 32'd1);
      step();
      ready = 1'b0;

      // start with count=0 in IDLE
      do_start(3'd5, 3'd1, 8'd0);
      chk("cnt0_valid", 32'(valid_o), 32'd0);
      chk("cnt0_busy", 32'(busy_o), 32'd0);
      step();
      chk("cnt0_done", 32'(done_o), 32'd0);

      // reset mid-sequence, during frame 2 of 5
      ready = 1'b1;
      exp_q.push_back(fr(1, 3, 5, 7));
      do_start(3'd1, 3'd2, 8'd5);
      step();
      chk("mid_frame2", 32'(frame), 32'(fr(2, 4, 6, 0)));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_sel", 32'(frame), 32'd0);
      chk("mid_rst_data0", 32'(d0), 32'd0);
      chk("mid_rst_data7", 32'(d7), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      chk("post_rst_busy", 32'(busy_o), 32'd0);
      chk("post_rst_done", 32'(done_o), 32'd0);
      exp_q.push_back(fr(4, 5, 6, 7));
      do_start(3'd4, 3'd1, 8'd1);
      chk("post_valid", 32'(valid_o), 32'd1);
      step();
      chk("post_done", 32'(done_o), 32'd1);
      step(); step();

      // final report
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("done_total", 32'(done_seen), 32'd4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
